// File: rtl/psram_resp.sv
// PSRAM serial-command responder: decodes RSTEN/RST (and Read ID when PSRAM_RESP_READID_EN is defined).
// Latency: cmd_valid/cmd_err/rsten_armed update on the edge that samples the 8th bit; ID bit 0 drives on the edge of address bit 23.
// Backpressure: none; mem_ce high aborts any transfer and all input is ignored while busy.
module psram_resp #(
    parameter bit          LSB_FIRST  = 1'b1,
    parameter int          RST_CYCLES = 16,
    parameter logic [7:0]  MFID       = 8'h0D,
    parameter logic [7:0]  KGD        = 8'h5D
) (
    input  logic       mem_clk,
    input  logic       rst_n,
    input  logic       mem_ce,
    inout  wire  [3:0] mem_sio,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       rsten_armed,
    output logic       busy,
    output logic       reset_done,
    output logic       cmd_err
);

`ifdef PSRAM_RESP_READID_EN
    localparam bit READID_EN = 1'b1;
`else
    localparam bit READID_EN = 1'b0;
`endif

    localparam logic [7:0]  OP_RSTEN = 8'h66;
    localparam logic [7:0]  OP_RST   = 8'h99;
    localparam logic [7:0]  OP_RDID  = 8'h9F;
    localparam logic [15:0] ID_WORD  = {MFID, KGD};

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DOUT, IGNORE, RESET} state_t;

    state_t      state, state_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [6:0]  sh, sh_nxt;
    logic [4:0]  addr_cnt, addr_cnt_nxt;
    logic [3:0]  dout_idx, dout_idx_nxt;
    logic [15:0] busy_cnt, busy_cnt_nxt;
    logic        rst_pend, rst_pend_nxt;
    logic        sio1_oe, sio1_oe_nxt;
    logic        sio1_dat, sio1_dat_nxt;
    logic        cmd_valid_nxt, cmd_err_nxt, reset_done_nxt, busy_nxt, armed_nxt;
    logic [7:0]  cmd_byte_nxt;
    logic        sin;
    logic [6:0]  sh_in;
    logic [7:0]  full_byte;

    assign sin = mem_sio[0];

    // The 7-bit shifter holds the earlier bits; the 8th bit completes the byte combinationally.
    always_comb begin
        if (LSB_FIRST) begin
            sh_in     = {sin, sh[6:1]};
            full_byte = {sin, sh};
        end else begin
            sh_in     = {sh[5:0], sin};
            full_byte = {sh, sin};
        end
    end

    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        sh_nxt         = sh;
        addr_cnt_nxt   = addr_cnt;
        dout_idx_nxt   = dout_idx;
        busy_cnt_nxt   = busy_cnt;
        rst_pend_nxt   = rst_pend;
        sio1_oe_nxt    = 1'b0;
        sio1_dat_nxt   = sio1_dat;
        cmd_valid_nxt  = 1'b0;
        cmd_err_nxt    = 1'b0;
        reset_done_nxt = 1'b0;
        busy_nxt       = 1'b0;
        armed_nxt      = rsten_armed;
        cmd_byte_nxt   = cmd_byte;
        case (state)
            IDLE: begin
                if (!mem_ce) begin
                    sh_nxt      = sh_in;
                    bit_cnt_nxt = 3'd1;
                    state_nxt   = CMD;
                end
            end
            CMD: begin
                if (mem_ce) begin
                    bit_cnt_nxt = 3'd0;
                    state_nxt   = IDLE;
                end else begin
                    sh_nxt      = sh_in;
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        cmd_byte_nxt  = full_byte;
                        cmd_valid_nxt = 1'b1;
                        state_nxt     = IGNORE;
                        if (full_byte == OP_RSTEN) begin
                            armed_nxt = 1'b1;
                        end else if (full_byte == OP_RST) begin
                            if (rsten_armed) begin
                                rst_pend_nxt = 1'b1;
                                armed_nxt    = 1'b0;
                            end else begin
                                cmd_err_nxt  = 1'b1;
                            end
                        end else if (READID_EN && full_byte == OP_RDID) begin
                            addr_cnt_nxt = 5'd0;
                            state_nxt    = ADDR;
                        end else begin
                            cmd_err_nxt = 1'b1;
                            armed_nxt   = 1'b0;
                        end
                    end
                end
            end
            ADDR: begin
                if (mem_ce) begin
                    addr_cnt_nxt = 5'd0;
                    state_nxt    = IDLE;
                end else if (addr_cnt == 5'd23) begin
                    addr_cnt_nxt = 5'd0;
                    sio1_oe_nxt  = 1'b1;
                    sio1_dat_nxt = ID_WORD[15];
                    dout_idx_nxt = 4'd1;
                    state_nxt    = DOUT;
                end else begin
                    addr_cnt_nxt = addr_cnt + 5'd1;
                end
            end
            DOUT: begin
                if (mem_ce) begin
                    dout_idx_nxt = 4'd0;
                    state_nxt    = IDLE;
                end else begin
                    // ~idx == 15-idx: MSB first, wrapping after 16 bits
                    sio1_oe_nxt  = 1'b1;
                    sio1_dat_nxt = ID_WORD[~dout_idx];
                    dout_idx_nxt = dout_idx + 4'd1;
                end
            end
            IGNORE: begin
                if (mem_ce) begin
                    if (rst_pend) begin
                        rst_pend_nxt = 1'b0;
                        busy_cnt_nxt = 16'(RST_CYCLES);
                        busy_nxt     = 1'b1;
                        state_nxt    = RESET;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            RESET: begin
                busy_nxt     = 1'b1;
                busy_cnt_nxt = busy_cnt - 16'd1;
                if (busy_cnt <= 16'd1) begin
                    busy_cnt_nxt   = 16'd0;
                    busy_nxt       = 1'b0;
                    reset_done_nxt = 1'b1;
                    cmd_byte_nxt   = 8'h00;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            sh          <= 7'd0;
            addr_cnt    <= 5'd0;
            dout_idx    <= 4'd0;
            busy_cnt    <= 16'd0;
            rst_pend    <= 1'b0;
            sio1_oe     <= 1'b0;
            sio1_dat    <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_err     <= 1'b0;
            reset_done  <= 1'b0;
            busy        <= 1'b0;
            rsten_armed <= 1'b0;
            cmd_byte    <= 8'h00;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            sh          <= sh_nxt;
            addr_cnt    <= addr_cnt_nxt;
            dout_idx    <= dout_idx_nxt;
            busy_cnt    <= busy_cnt_nxt;
            rst_pend    <= rst_pend_nxt;
            sio1_oe     <= sio1_oe_nxt;
            sio1_dat    <= sio1_dat_nxt;
            cmd_valid   <= cmd_valid_nxt;
            cmd_err     <= cmd_err_nxt;
            reset_done  <= reset_done_nxt;
            busy        <= busy_nxt;
            rsten_armed <= armed_nxt;
            cmd_byte    <= cmd_byte_nxt;
        end
    end

    assign mem_sio[1]   = (READID_EN && sio1_oe) ? sio1_dat : 1'bz;
    assign mem_sio[3:2] = 2'bzz;

endmodule

// File: doc/psram_resp.md
# psram_resp

Cycle-based responder for the PSRAM serial command interface, the device side of the link driven by the PSRAM initialization controller. It samples `mem_ce`/`mem_sio[0]` on `mem_clk` and decodes 8-bit commands: RSTEN, RST and optionally Read ID. It executes the reset handshake and can return ID bytes on `mem_sio[1]`. It is used as the memory model in simulation benches and as a loopback target on the Tang Nano 1k.

## Interface
- `LSB_FIRST`, 1: command bits arrive LSB first when 1, MSB first when 0; ID data is always driven MSB first
- `RST_CYCLES`, 16: number of busy cycles after an accepted RST; legal range 1..65535
- `MFID`, 8'h0D: manufacturer ID byte
- `KGD`, 8'h5D: known-good-die byte
- `mem_clk` input 1: the only clock, rising edge
- `rst_n` input 1: synchronous, active-low reset
- `mem_ce` input 1: chip enable, active low
- `mem_sio` inout 4: `[0]` is serial data in; `[1]` is driven only while the ID is being output and is `z` otherwise; `[3:2]` are always `z`
- `cmd_valid` output 1: one-cycle pulse when a command byte completes
- `cmd_byte` output 8: last completed command byte, held until the next one
- `rsten_armed` output 1: reset-enable latch
- `busy` output 1: reset in progress
- `reset_done` output 1: one-cycle pulse at the end of the busy period
- `cmd_err` output 1: one-cycle pulse for an unknown command, or for RST while not armed

## Operation
- States: IDLE, CMD, ADDR, DOUT, IGNORE, RESET.
- IDLE: when `mem_ce`=0, sample bit 0 of the command, clear `bit_cnt` to 1 and go to CMD.
- CMD: shift in one bit per cycle while `mem_ce`=0. On the 8th bit:
  - Register `cmd_byte`.
  - Assert `cmd_valid` on the next cycle.
- Decode of 8'h66 (RSTEN): set `rsten_armed`, then go to IGNORE.
- Decode of 8'h99 (RST):
  - If `rsten_armed`=1, mark RST pending, go to IGNORE, and clear `rsten_armed`.
  - Otherwise pulse `cmd_err` and go to IGNORE.
- Decode of 8'h9F (Read ID): go to ADDR. 24 address bits are sampled and discarded, then go to DOUT.
- Any other byte: pulse `cmd_err`, clear `rsten_armed`, go to IGNORE.
- IGNORE: ignore `mem_sio`. When `mem_ce`=1 is sampled:
  - If RST is pending, go to RESET and load the busy counter with `RST_CYCLES`.
  - Otherwise go to IDLE.
- RESET:
  - `busy`=1 and all inputs are ignored, including `mem_ce` activity.
  - Decrement the counter each cycle. At 0, pulse `reset_done`, clear `cmd_byte` to 0, and go to IDLE.
- DOUT: drive `{MFID,KGD}` MSB first on `mem_sio[1]`, one bit per cycle. After 16 bits, wrap and repeat until `mem_ce`=1.
- `mem_ce`=1 sampled in CMD, ADDR or DOUT: abort to IDLE. The partial byte is discarded, no `cmd_valid` is issued, `rsten_armed` is unchanged, and `mem_sio[1]` returns to `z` on the same edge.

## Timing
- Reset values, while `rst_n`=0 at a rising edge:
  - State is IDLE; all counters are 0.
  - `cmd_valid`=0, `cmd_byte`=0, `rsten_armed`=0, `busy`=0, `reset_done`=0, `cmd_err`=0.
  - `mem_sio` is all `z`.
- `rst_n` overrides every state, including RESET and DOUT, on the same edge.
- The first command bit is sampled on the first edge with `mem_ce`=0, so a byte spans 8 consecutive low cycles.
- `cmd_valid` and `cmd_err` assert 1 cycle after the edge that samples the 8th bit.
- `rsten_armed` follows the same 1-cycle delay as `cmd_valid`.
- `busy` rises 1 cycle after the first edge that samples `mem_ce` high following an accepted RST. It stays high for exactly `RST_CYCLES` cycles.
- `reset_done` pulses in the cycle where `busy` falls.
- In the cycle `reset_done` pulses, `busy` is 0 and the next `mem_ce`=0 is accepted.
- Read ID: the first data bit (MFID[7]) is driven from the edge that samples address bit 23. Each following edge advances one bit.
- Simultaneous events:
  - `mem_ce` rising on the same edge as the 8th command bit: the bit is not sampled, because `mem_ce`=1 wins.
  - RSTEN followed by a non-RST byte: the latch is cleared.

## Configuration
- `PSRAM_RESP_READID_EN` defined: Read ID (8'h9F) support, the ADDR and DOUT states, and the `mem_sio[1]` driver are compiled in.
- `PSRAM_RESP_READID_EN` undefined: 8'h9F is decoded as an unknown command (`cmd_err` pulse, IGNORE), and `mem_sio[1]` is permanently `z`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `mem_ce`=0 and toggling `sio[0]` -> all outputs at their reset values, `mem_sio`=`zzzz`, no `cmd_valid`.
- 8'h66 LSB first, `mem_ce` high, then 8'h99, then `mem_ce` high:
  - -> `cmd_valid` twice, with `cmd_byte` 66 then 99.
  - -> `rsten_armed` 1 then 0.
  - -> `busy` for exactly 16 cycles, then `reset_done`=1 for 1 cycle.
- 8'h99 without a prior RSTEN -> `cmd_err`=1 for 1 cycle, `busy` never asserts.
- 8'h66 then 8'h35 -> `cmd_err`, `rsten_armed` returns to 0; a following 8'h99 -> `cmd_err`, no reset.
- `mem_ce` high after 5 bits of 8'h66 -> no `cmd_valid`, state IDLE; a full 8'h66 then works normally.
- With `PSRAM_RESP_READID_EN`: 8'h9F + 24 zeros, then 20 cycles -> `sio[1]` = `0000_1101_0101_1101_0000`; `z` after `mem_ce` rises. Without the macro -> `cmd_err`, `sio[1]` stays `z`.
